// File: rtl/salu_issue_arbiter.sv
// Round-robin issue arbiter in front of the scalar ALU. s_nop and s_endpgm retire locally as
// per-wave stalls and completions; every other granted instruction goes to a registered slot.
module salu_issue_arbiter #(
  parameter int unsigned NUM_WAVES = 4,
  parameter int unsigned INSTR_W   = 32,
  localparam int unsigned WID_W    = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WAVES-1:0]           req_valid,
  input  logic [NUM_WAVES*INSTR_W-1:0]   req_instr,
  output logic [NUM_WAVES-1:0]           req_ready,
  input  logic [NUM_WAVES-1:0]           wave_launch,
  output logic [NUM_WAVES-1:0]           wave_done,
  output logic                           salu_valid,
  output logic [INSTR_W-1:0]             salu_instr,
  output logic [WID_W-1:0]               salu_wave_id,
  input  logic                           salu_ready
);

  logic [NUM_WAVES-1:0][3:0] r_stall;
  logic [NUM_WAVES-1:0]      r_done;
  logic [NUM_WAVES-1:0]      r_wave_done;
  logic [WID_W-1:0]          r_rr_ptr;
  logic                      r_salu_valid;
  logic [INSTR_W-1:0]        r_salu_instr;
  logic [WID_W-1:0]          r_salu_wave_id;

  logic [NUM_WAVES-1:0] w_eligible;
  logic                 w_slot_free;
  logic                 w_grant_vld;
  logic [WID_W-1:0]     w_grant_id;
  int unsigned          w_idx;
  logic [INSTR_W-1:0]   w_g_instr;
  logic                 w_is_sopp;
  logic                 w_is_nop;
  logic                 w_is_end;
  logic                 w_grant_fwd;
  logic [3:0]           w_nop_cnt;
  logic [WID_W-1:0]     w_rr_next;

  assign w_slot_free = ~r_salu_valid | salu_ready;

  always_comb begin
    for (int w = 0; w < NUM_WAVES; w++) begin
      w_eligible[w] = req_valid[w] & ~r_done[w] & (r_stall[w] == 4'd0);
    end
  end

  // First eligible wave at or after rr_ptr, wrapping; reset low blocks any grant.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_idx       = 0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % NUM_WAVES;
      if (!w_grant_vld && w_eligible[WID_W'(w_idx)]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = WID_W'(w_idx);
      end
    end
    w_grant_vld = w_grant_vld & w_slot_free & rst_n;
  end

  always_comb begin
    for (int w = 0; w < NUM_WAVES; w++) begin
      req_ready[w] = w_grant_vld && (w_grant_id == WID_W'(w));
    end
  end

  assign w_g_instr   = req_instr[w_grant_id*INSTR_W +: INSTR_W];
  assign w_is_sopp   = (w_g_instr[31:23] == 9'b1_0111_1111);
  assign w_is_nop    = w_is_sopp && (w_g_instr[22:16] == 7'd0);
  assign w_is_end    = w_is_sopp && (w_g_instr[22:16] == 7'd1);
  assign w_grant_fwd = w_grant_vld & ~w_is_nop & ~w_is_end;
  assign w_nop_cnt   = (w_g_instr[3:0] == 4'hF) ? 4'hF : w_g_instr[3:0] + 4'd1;
  assign w_rr_next   = (w_grant_id == WID_W'(NUM_WAVES - 1)) ? '0 : w_grant_id + WID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr       <= '0;
      r_salu_valid   <= 1'b0;
      r_salu_instr   <= '0;
      r_salu_wave_id <= '0;
    end else begin
      if (w_grant_vld) r_rr_ptr <= w_rr_next;
      if (w_grant_fwd) begin
        r_salu_valid   <= 1'b1;
        r_salu_instr   <= w_g_instr;
        r_salu_wave_id <= w_grant_id;
      end else if (w_slot_free) begin
        r_salu_valid <= 1'b0;
      end
    end
  end

  // Launch overrides a same-cycle local instruction to the same wave (and hides its done pulse).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall     <= '0;
      r_done      <= '0;
      r_wave_done <= '0;
    end else begin
      for (int w = 0; w < NUM_WAVES; w++) begin
        r_wave_done[w] <= 1'b0;
        if (wave_launch[w]) begin
          r_done[w]  <= 1'b0;
          r_stall[w] <= 4'd0;
        end else if (req_ready[w] && w_is_nop) begin
          r_stall[w] <= w_nop_cnt;
        end else if (req_ready[w] && w_is_end) begin
          r_done[w]      <= 1'b1;
          r_wave_done[w] <= 1'b1;
        end else if (r_stall[w] != 4'd0) begin
          r_stall[w] <= r_stall[w] - 4'd1;
        end
      end
    end
  end

  assign wave_done    = r_wave_done;
  assign salu_valid   = r_salu_valid;
  assign salu_instr   = r_salu_instr;
  assign salu_wave_id = r_salu_wave_id;

endmodule

// File: doc/salu_issue_arbiter.md
# salu_issue_arbiter

Round-robin issue arbiter and sequencer in front of the scalar ALU of the RDNA2 compute unit. Each wave slot presents one 32-bit scalar instruction; the arbiter grants at most one per cycle and forwards it through a registered valid/ready slot to the scalar ALU. The SOPP control instructions s_nop and s_endpgm are executed locally: per-wave stalls and wave completion. They are never forwarded.

## Interface
- NUM_WAVES, 4: number of wave slots (≥2); WID_W = clog2(NUM_WAVES)
- INSTR_W, 32: scalar instruction width (fixed 32)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_WAVES  wave w presents an instruction
- req_instr  in  NUM_WAVES*32  instruction of wave w at bits [32w+31:32w]
- req_ready  out  NUM_WAVES  one-hot (or zero) grant; instruction of wave w consumed this cycle
- wave_launch  in  NUM_WAVES  pulse; (re)starts wave w
- wave_done  out  NUM_WAVES  one-cycle pulse after wave w retires s_endpgm
- salu_valid  out  1  forwarded instruction valid
- salu_instr  out  32  forwarded instruction
- salu_wave_id  out  WID_W  source wave of salu_instr
- salu_ready  in  1  scalar ALU accepts salu_instr

## Operation
- SOPP decode: instr[31:23] == 9'b1_0111_1111; op = instr[22:16]; simm16 = instr[15:0]. s_nop: SOPP, op 0. s_endpgm: SOPP, op 1.
- Per-wave state: stall_cnt[w] (4 bits), done[w] (1 bit).
- Eligible(w) = req_valid[w] & ~done[w] & (stall_cnt[w] == 0).
- Slot free = ~salu_valid | salu_ready. Arbitration runs only when the slot is free. Otherwise req_ready = 0.
- Round-robin: search starts at rr_ptr and wraps modulo NUM_WAVES. The first eligible wave g is granted: req_ready[g] = 1, combinational.
- After a grant, rr_ptr <= (g+1) mod NUM_WAVES. With no grant, rr_ptr holds.
- Normal instruction granted: salu_instr <= instr, salu_wave_id <= g, salu_valid <= 1.
- s_nop granted: consumed but not forwarded. stall_cnt[g] <= simm16[3:0] + 1, saturating at 15 for simm16[3:0] == 15. Wave g is ineligible for that many cycles.
- s_endpgm granted: consumed but not forwarded. done[g] <= 1, and wave_done[g] pulses the next cycle. The wave stays ineligible until launched again.
- When a local instruction (s_nop or s_endpgm) is granted, salu_valid <= 0 if the slot was draining. The grant still uses that cycle's arbitration slot.
- stall_cnt[w] decrements by 1 per cycle while nonzero. A cycle in which it is loaded is not also a decrement cycle.
- wave_launch[w]: done[w] <= 0 and stall_cnt[w] <= 0.
  - It has priority over a same-cycle s_endpgm or s_nop grant to w. The instruction is still consumed.
  - wave_done[w] is suppressed in that case.
- Output slot holds salu_instr / salu_wave_id stable while salu_valid & ~salu_ready. It clears (salu_valid <= 0) when drained with no new grant.

## Timing
- Reset (async assert, sync-to-clk deassert usage) puts the block in this state:
  - salu_valid = 0, salu_instr = 0, salu_wave_id = 0
  - wave_done = 0, rr_ptr = 0
  - all stall_cnt = 0, all done = 0
- req_ready is 0 while rst_n is low.
- Latency: a grant in cycle t appears at salu_valid/salu_instr in cycle t+1.
- Throughput: 1 instruction/cycle while salu_ready = 1.
- Backpressure: salu_ready = 0 with salu_valid = 1 gives req_ready = 0, and the output is held. Arbitration resumes in the same cycle salu_ready returns to 1.
- s_nop with simm16[3:0] = N granted in cycle t: the wave becomes eligible again in cycle t+N+2.
- s_endpgm granted in cycle t: wave_done pulses in cycle t+1.
- Reset mid-operation: any in-flight slot contents are discarded; no wave_done pulse is generated.
- All req_valid = 0: no grant, rr_ptr unchanged, stall counters still decrement.

## Test plan
- Reset: drive rst_n = 0 with all req_valid = 1 -> req_ready = 0, salu_valid = 0, wave_done = 0. Release, salu_ready = 1 -> wave 0 is granted first and salu_wave_id = 0 one cycle later.
- Fairness: NUM_WAVES = 4, all req_valid = 1 with normal instructions (e.g. 0xBE800080), salu_ready = 1 -> salu_wave_id sequence is 0,1,2,3,0,… at one per cycle.
- Backpressure: hold salu_ready = 0 for 3 cycles with salu_valid = 1 -> salu_instr/salu_wave_id are stable and req_ready = 0. Releasing -> the next wave in round-robin order is granted the same cycle.
- s_nop: wave 1 issues 0xBF800003 (N = 3) at cycle t while others are idle -> it is not forwarded (salu_valid = 0 at t+1). Wave 1 is not granted during t+1..t+4 and is granted at t+5.
- s_endpgm: wave 2 issues 0xBF810000 at cycle t -> wave_done = 4'b0100 at t+1 only; later req_valid[2] is ignored. wave_launch[2] pulse -> wave 2 is granted again the following cycle.
- Collision: wave_launch[3] in the same cycle wave 3's s_endpgm is granted -> req_ready[3] = 1, no wave_done[3] pulse, and wave 3 remains eligible.
